// File: rtl/mips_defs.sv
// ============================================================================
// mips_defs : opcode/funct, ALU, select and FSM state encodings shared by the
//             multi-cycle MIPS control unit, ALU and datapath.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_SRL  = 3'd4;
   localparam logic [2:0] ALU_SRA  = 3'd5;

   localparam logic [1:0] PCSEL_PC4  = 2'd0;
   localparam logic [1:0] PCSEL_BR   = 2'd1;
   localparam logic [1:0] PCSEL_JUMP = 2'd2;
   localparam logic [1:0] PCSEL_REG  = 2'd3;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] WDSEL_ALU = 2'd0;
   localparam logic [1:0] WDSEL_MEM = 2'd1;
   localparam logic [1:0] WDSEL_PC  = 2'd2;

   localparam logic [1:0] EXT_ZERO  = 2'd0;
   localparam logic [1:0] EXT_SIGN  = 2'd1;
   localparam logic [1:0] EXT_LUI   = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXE_R   = 4'd2,
      S_EXE_I   = 4'd3,
      S_WB_R    = 4'd4,
      S_WB_I    = 4'd5,
      S_MEM_ADR = 4'd6,
      S_MEM_RD  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_WB_MEM  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   typedef enum logic [3:0] {
      C_RALU = 4'd0,
      C_ORI  = 4'd1,
      C_LUI  = 4'd2,
      C_LW   = 4'd3,
      C_SW   = 4'd4,
      C_BEQ  = 4'd5,
      C_J    = 4'd6,
      C_JAL  = 4'd7,
      C_JR   = 4'd8,
      C_ILL  = 4'd9
   } iclass_t;

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_dec.sv
// ============================================================================
// mc_ctrl_dec : combinational decode of Op/Funct into an instruction class
//               and the ALU opcode used by R-type arithmetic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_dec
   import mips_defs::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic [2:0] r_alu_op
);

   always_comb begin
      iclass   = C_ILL;
      r_alu_op = ALU_ADD;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: begin iclass = C_RALU; r_alu_op = ALU_ADD; end
               FN_SUBU: begin iclass = C_RALU; r_alu_op = ALU_SUB; end
               FN_AND:  begin iclass = C_RALU; r_alu_op = ALU_AND; end
               FN_OR:   begin iclass = C_RALU; r_alu_op = ALU_OR;  end
               FN_JR:   iclass = C_JR;
               default: iclass = C_ILL;
            endcase
         end
         OP_ORI:  iclass = C_ORI;
         OP_LUI:  iclass = C_LUI;
         OP_LW:   iclass = C_LW;
         OP_SW:   iclass = C_SW;
         OP_BEQ:  iclass = C_BEQ;
         OP_J:    iclass = C_J;
         OP_JAL:  iclass = C_JAL;
         default: iclass = C_ILL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// ============================================================================
// mc_ctrl : multi-cycle MIPS control FSM driving ALU opcode and all datapath
//           enables/selects from the latched IR fields and the ALU Zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_ctrl
   import mips_defs::*;
#(
   parameter int STATE_W        = 4,
   parameter bit NOP_ON_ILLEGAL = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   output logic               PCWr,
   output logic [1:0]         PCSel,
   output logic               IRWr,
   output logic               RegWr,
   output logic [1:0]         RegDst,
   output logic [1:0]         WDSel,
   output logic [1:0]         ExtOp,
   output logic               ALUSrc,
   output logic [2:0]         ALUOp,
   output logic               MemWr,
   output logic               Illegal,
   output logic [STATE_W-1:0] State
);

   state_t     state_q, state_d;
   iclass_t    iclass;
   logic [2:0] r_alu_op;
   logic       pc_wr, ir_wr, reg_wr, mem_wr;

   mc_ctrl_dec u_dec (
      .op       (Op),
      .funct    (Funct),
      .iclass   (iclass),
      .r_alu_op (r_alu_op)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      PCSel   = PCSEL_PC4;
      RegDst  = REGDST_RT;
      WDSel   = WDSEL_ALU;
      ExtOp   = EXT_ZERO;
      ALUSrc  = 1'b0;
      ALUOp   = ALU_ADD;
      Illegal = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (iclass)
               C_RALU:       state_d = S_EXE_R;
               C_ORI, C_LUI: state_d = S_EXE_I;
               C_LW, C_SW:   state_d = S_MEM_ADR;
               C_BEQ:        state_d = S_BRANCH;
               C_J, C_JAL,
               C_JR:         state_d = S_JUMP;
               default: begin
                  Illegal = 1'b1;
                  state_d = NOP_ON_ILLEGAL ? S_FETCH : S_HALT;
               end
            endcase
         end
         S_EXE_R: begin
            ALUOp   = r_alu_op;
            state_d = S_WB_R;
         end
         S_WB_R: begin
            ALUOp   = r_alu_op;
            reg_wr  = 1'b1;
            RegDst  = REGDST_RD;
            WDSel   = WDSEL_ALU;
         end
         S_EXE_I, S_WB_I: begin
            ALUSrc = 1'b1;
            // lui relies on rs being $0 so ADD passes the shifted immediate
            if (iclass == C_LUI) begin
               ExtOp = EXT_LUI;
               ALUOp = ALU_ADD;
            end else begin
               ExtOp = EXT_ZERO;
               ALUOp = ALU_OR;
            end
            if (state_q == S_WB_I) begin
               reg_wr = 1'b1;
               RegDst = REGDST_RT;
               WDSel  = WDSEL_ALU;
            end else begin
               state_d = S_WB_I;
            end
         end
         S_MEM_ADR: begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_SIGN;
            ALUOp   = ALU_ADD;
            state_d = (iclass == C_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_SIGN;
            ALUOp   = ALU_ADD;
            state_d = S_WB_MEM;
         end
         S_MEM_WR: begin
            ALUSrc  = 1'b1;
            ExtOp   = EXT_SIGN;
            ALUOp   = ALU_ADD;
            mem_wr  = 1'b1;
         end
         S_WB_MEM: begin
            reg_wr  = 1'b1;
            RegDst  = REGDST_RT;
            WDSel   = WDSEL_MEM;
         end
         S_BRANCH: begin
            ALUSrc  = 1'b0;
            ALUOp   = ALU_SUB;
            ExtOp   = EXT_SIGN;
            PCSel   = PCSEL_BR;
            pc_wr   = Zero;
         end
         S_JUMP: begin
            pc_wr = 1'b1;
            case (iclass)
               C_JR:  PCSel = PCSEL_REG;
               C_JAL: begin
                  PCSel  = PCSEL_JUMP;
                  reg_wr = 1'b1;
                  RegDst = REGDST_RA;
                  WDSel  = WDSEL_PC;
               end
               default: PCSel = PCSEL_JUMP;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Write strobes are masked while reset is held so nothing retires during it
   assign PCWr  = pc_wr  & ~reset;
   assign IRWr  = ir_wr  & ~reset;
   assign RegWr = reg_wr & ~reset;
   assign MemWr = mem_wr & ~reset;
   assign State = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl.sv
// ============================================================================
// tb_mc_ctrl : directed scoreboard bench for mc_ctrl (both illegal policies).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mc_ctrl;
   import mips_defs::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcwr;
      logic [1:0] pcsel;
      logic       irwr;
      logic       regwr;
      logic [1:0] regdst;
      logic [1:0] wdsel;
      logic [1:0] extop;
      logic       alusrc;
      logic [2:0] aluop;
      logic       memwr;
      logic       illegal;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;

   logic       a_pcwr, a_irwr, a_regwr, a_alusrc, a_memwr, a_ill;
   logic [1:0] a_pcsel, a_regdst, a_wdsel, a_extop;
   logic [2:0] a_aluop;
   logic [3:0] a_st;
   logic       b_pcwr, b_irwr, b_regwr, b_alusrc, b_memwr, b_ill;
   logic [1:0] b_pcsel, b_regdst, b_wdsel, b_extop;
   logic [2:0] b_aluop;
   logic [3:0] b_st;

   exp_t got_a, got_b;
   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.STATE_W(4), .NOP_ON_ILLEGAL(1'b1)) u_dut (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero),
      .PCWr(a_pcwr), .PCSel(a_pcsel), .IRWr(a_irwr), .RegWr(a_regwr),
      .RegDst(a_regdst), .WDSel(a_wdsel), .ExtOp(a_extop), .ALUSrc(a_alusrc),
      .ALUOp(a_aluop), .MemWr(a_memwr), .Illegal(a_ill), .State(a_st)
   );

   mc_ctrl #(.STATE_W(4), .NOP_ON_ILLEGAL(1'b0)) u_halt (
      .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero),
      .PCWr(b_pcwr), .PCSel(b_pcsel), .IRWr(b_irwr), .RegWr(b_regwr),
      .RegDst(b_regdst), .WDSel(b_wdsel), .ExtOp(b_extop), .ALUSrc(b_alusrc),
      .ALUOp(b_aluop), .MemWr(b_memwr), .Illegal(b_ill), .State(b_st)
   );

   assign got_a = {a_st, a_pcwr, a_pcsel, a_irwr, a_regwr, a_regdst, a_wdsel,
                   a_extop, a_alusrc, a_aluop, a_memwr, a_ill};
   assign got_b = {b_st, b_pcwr, b_pcsel, b_irwr, b_regwr, b_regdst, b_wdsel,
                   b_extop, b_alusrc, b_aluop, b_memwr, b_ill};

   function automatic exp_t e(input state_t s);
      exp_t x;
      x    = '0;
      x.st = s;
      return x;
   endfunction

   task automatic check(input string tag, input exp_t got, input exp_t want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h (st got=%0d want=%0d)", tag, got, want, got.st, want.st);
      end
   endtask

   // Expected per-cycle vectors for one instruction, written from the ISA table
   task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
      exp_t x;
      x = e(S_FETCH); x.pcwr = 1; x.irwr = 1; q.push_back(x);
      x = e(S_DECODE);
      if (o == 6'b000000 && (f == 6'b100001 || f == 6'b100011 || f == 6'b100100 || f == 6'b100101)) begin
         q.push_back(x);
         x = e(S_EXE_R);
         x.aluop = (f == 6'b100001) ? 3'd0 : (f == 6'b100011) ? 3'd1 : (f == 6'b100100) ? 3'd2 : 3'd3;
         q.push_back(x);
         x.st = S_WB_R; x.regwr = 1; x.regdst = 2'd1; q.push_back(x);
      end else if (o == 6'b001101 || o == 6'b001111) begin
         q.push_back(x);
         x = e(S_EXE_I); x.alusrc = 1;
         if (o == 6'b001111) begin x.extop = 2'd2; x.aluop = 3'd0; end
         else                begin x.extop = 2'd0; x.aluop = 3'd3; end
         q.push_back(x);
         x.st = S_WB_I; x.regwr = 1; q.push_back(x);
      end else if (o == 6'b100011) begin
         q.push_back(x);
         x = e(S_MEM_ADR); x.alusrc = 1; x.extop = 2'd1; q.push_back(x);
         x.st = S_MEM_RD; q.push_back(x);
         x = e(S_WB_MEM); x.regwr = 1; x.wdsel = 2'd1; q.push_back(x);
      end else if (o == 6'b101011) begin
         q.push_back(x);
         x = e(S_MEM_ADR); x.alusrc = 1; x.extop = 2'd1; q.push_back(x);
         x.st = S_MEM_WR; x.memwr = 1; q.push_back(x);
      end else if (o == 6'b000100) begin
         q.push_back(x);
         x = e(S_BRANCH); x.aluop = 3'd1; x.extop = 2'd1; x.pcsel = 2'd1; x.pcwr = z;
         q.push_back(x);
      end else if (o == 6'b000010 || o == 6'b000011 || (o == 6'b000000 && f == 6'b001000)) begin
         q.push_back(x);
         x = e(S_JUMP); x.pcwr = 1;
         if (o == 6'b000000) x.pcsel = 2'd3;
         else                x.pcsel = 2'd2;
         if (o == 6'b000011) begin x.regwr = 1; x.regdst = 2'd2; x.wdsel = 2'd2; end
         q.push_back(x);
      end else begin
         x.illegal = 1; q.push_back(x);
      end
   endtask

   // Drive one instruction and pop/compare one vector per cycle (both DUTs)
   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int stop_after);
      int n;
      exp_t w;
      op = o; funct = f; zero = z;
      push_instr(o, f, z);
      n = 0;
      while (q.size() > 0 && n < stop_after) begin
         #1;
         w = q.pop_front();
         check({tag, "/a"}, got_a, w);
         check({tag, "/b"}, got_b, w);
         n++;
         if (q.size() > 0 && n < stop_after) @(negedge clk);
      end
      if (q.size() == 0) @(negedge clk);
   endtask

   initial begin
      exp_t w;
      reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
      @(negedge clk); #1;
      check("reset_hold", got_a, e(S_FETCH));
      reset = 1'b0;

      run_instr("addu", 6'b000000, 6'b100001, 1'b0, 99);
      run_instr("subu", 6'b000000, 6'b100011, 1'b1, 99);
      run_instr("and",  6'b000000, 6'b100100, 1'b0, 99);
      run_instr("or",   6'b000000, 6'b100101, 1'b0, 99);
      run_instr("ori",  6'b001101, 6'b111111, 1'b0, 99);
      run_instr("lui",  6'b001111, 6'b000000, 1'b0, 99);
      run_instr("lw",   6'b100011, 6'b000000, 1'b0, 99);
      run_instr("sw",   6'b101011, 6'b000000, 1'b0, 99);
      run_instr("beq1", 6'b000100, 6'b000000, 1'b1, 99);
      run_instr("beq0", 6'b000100, 6'b000000, 1'b0, 99);
      run_instr("j",    6'b000010, 6'b000000, 1'b0, 99);
      run_instr("jal",  6'b000011, 6'b000000, 1'b0, 99);
      run_instr("jr",   6'b000000, 6'b001000, 1'b0, 99);

      // sw interrupted by reset while sitting in S_MEM_WR
      run_instr("sw_pre", 6'b101011, 6'b000000, 1'b0, 3);
      @(negedge clk); #1;
      w = q.pop_front();
      check("sw_memwr", got_a, w);
      q.delete();
      reset = 1'b1; #1;
      check("rst_async", got_a, e(S_FETCH));
      @(negedge clk); #1;
      check("rst_gated", got_b, e(S_FETCH));
      reset = 1'b0; #1;
      w = e(S_FETCH); w.pcwr = 1; w.irwr = 1;
      check("rst_release", got_a, w);

      run_instr("addu2", 6'b000000, 6'b100001, 1'b0, 99);
      run_instr("ill",   6'b111111, 6'b000000, 1'b0, 99);

      #1;
      w = e(S_FETCH); w.pcwr = 1; w.irwr = 1;
      check("ill_nop", got_a, w);
      for (int i = 0; i < 10; i++) begin
         check("halt_hold", got_b, e(S_HALT));
         @(negedge clk); #1;
      end
      reset = 1'b1; #1;
      check("halt_reset", got_b, e(S_FETCH));
      reset = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit: the initiator side of the ALU interface.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the ALU's 3-bit opcode (0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra) and all datapath enables.
- Sits beside the datapath (PC, IR, GRF, EXT, ALU, DM); consumes latched IR opcode/funct and the ALU Zero flag.

Parameters:
- STATE_W, 4, width of state register and State debug port.
- NOP_ON_ILLEGAL, 1, 1: unknown instruction retires as a nop; 0: enter S_HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces S_FETCH
- Op  in  6  IR[31:26], valid from S_DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU result == 0
- PCWr  out  1  PC write enable
- PCSel  out  2  0 PC+4, 1 branch target, 2 jump target {PC[31:28],imm26,00}, 3 GRF[rs]
- IRWr  out  1  IR write enable
- RegWr  out  1  GRF write enable
- RegDst  out  2  0 rt, 1 rd, 2 $31
- WDSel  out  2  0 ALU result, 1 DM read data, 2 PC (already PC+4)
- ExtOp  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
- ALUSrc  out  1  0 GRF[rt], 1 EXT output
- ALUOp  out  3  ALU opcode, encoding above
- MemWr  out  1  DM write enable
- Illegal  out  1  high in S_DECODE when Op/Funct unsupported
- State  out  STATE_W  current state, debug

Behaviour:
- Supported: addu, subu, and, or, jr (Op 000000, Funct 100001/100011/100100/100101/001000); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
- States: S_FETCH, S_DECODE, S_EXE_R, S_EXE_I, S_WB_R, S_WB_I, S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT.
- Moore outputs, decoded from the state register plus Op/Funct only. Defaults are all enables 0, selects 0, ALUOp 0.
- S_FETCH: IRWr=1, PCWr=1, PCSel=0. Next is S_DECODE.
- S_DECODE: no writes. Next state:
  - R-ALU → S_EXE_R
  - ori/lui → S_EXE_I
  - lw/sw → S_MEM_ADR
  - beq → S_BRANCH
  - j/jal/jr → S_JUMP
  - unsupported → Illegal=1; S_FETCH if NOP_ON_ILLEGAL else S_HALT
- S_EXE_R: ALUSrc=0; ALUOp = 0 addu, 1 subu, 2 and, 3 or. Next is S_WB_R.
- S_WB_R: ALUOp held; RegWr=1, RegDst=1, WDSel=0. Next is S_FETCH.
- S_EXE_I:
  - ori: ALUSrc=1, ExtOp=0, ALUOp=3.
  - lui: ALUSrc=1, ExtOp=2, ALUOp=0 (rs is $0).
  - Next is S_WB_I.
- S_WB_I: same ALU controls; RegWr=1, RegDst=0, WDSel=0. Next is S_FETCH.
- S_MEM_ADR: ALUSrc=1, ExtOp=1, ALUOp=0. Next is S_MEM_RD (lw) or S_MEM_WR (sw).
- S_MEM_RD: address controls held. Next is S_WB_MEM.
- S_WB_MEM: RegWr=1, RegDst=0, WDSel=1. Next is S_FETCH.
- S_MEM_WR: address controls held; MemWr=1. Next is S_FETCH.
- S_BRANCH: ALUSrc=0, ALUOp=1, ExtOp=1, PCSel=1, PCWr=Zero (the only Mealy output). Next is S_FETCH.
- S_JUMP: PCWr=1. Next is S_FETCH.
  - j: PCSel=2.
  - jal: PCSel=2, plus RegWr=1, RegDst=2, WDSel=2; the GRF captures PC+4 on the same edge PC updates.
  - jr: PCSel=3.
- S_HALT: all enables 0; stays until reset.
- Cycle counts: beq/j/jal/jr 3; R-type, ori, lui and sw 4; lw 5; illegal nop 2.
- Reset:
  - Asynchronous: state = S_FETCH immediately.
  - While reset is high, PCWr, IRWr, RegWr and MemWr are forced 0 (gated). The first fetch happens on the first rising edge after reset deasserts.
  - Reset mid-instruction abandons it; no partial write occurs after assertion.
- Unused state codes decode to S_FETCH next, with all enables 0.
- At most one of RegWr and MemWr is high in any cycle.

Decomposition:
- Shared package `mips_defs`, holding:
  - opcode and funct constants
  - ALUOp codes 0–5
  - PCSel, RegDst, WDSel and ExtOp encodings
  - state encodings
- The ALU and datapath include the same package.
- One natural sub-module: `mc_ctrl_dec`, a combinational decode of Op/Funct into an instruction class plus R-type ALUOp. The FSM stays in mc_ctrl.

Test Plan:
- Reset high mid-S_MEM_WR, then released → State=S_FETCH at once; MemWr=0 during reset; IRWr=1 on the first cycle after release.
- addu (Op 0, Funct 100001) → states FETCH, DECODE, EXE_R, WB_R; RegWr=1 only in WB_R with RegDst=1; ALUOp=0 in EXE_R/WB_R; back to FETCH after 4 cycles.
- lw (Op 100011) → 5 states; ExtOp=1, ALUOp=0 in MEM_ADR; RegWr=1, WDSel=1 only in WB_MEM. sw (101011) → MemWr=1 exactly one cycle, RegWr never set.
- beq with Zero=1 → PCWr=1, PCSel=1 in S_BRANCH, ALUOp=1. Same with Zero=0 → PCWr=0, 3-cycle return to FETCH.
- jal (000011) → S_JUMP: PCWr=1, PCSel=2, RegWr=1, RegDst=2, WDSel=2. jr (Op 0, Funct 001000) → PCSel=3, RegWr=0.
- Op 111111 → Illegal=1 in DECODE. NOP_ON_ILLEGAL=1: next State=S_FETCH. NOP_ON_ILLEGAL=0: State=S_HALT held for 10 cycles with all enables 0.
